// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the MMIO port responder slice.
//   - Register word offsets within the 32-byte window
//   - CTRL / IRQMASK bit indices
//   - Timer state encoding
//   - Window hit helper
package mmio_pkg;

  localparam logic [4:0] OFF_IN      = 5'h00;
  localparam logic [4:0] OFF_OUT     = 5'h04;
  localparam logic [4:0] OFF_EDGE    = 5'h08;
  localparam logic [4:0] OFF_COUNT   = 5'h0C;
  localparam logic [4:0] OFF_COMPARE = 5'h10;
  localparam logic [4:0] OFF_CTRL    = 5'h14;
  localparam logic [4:0] OFF_IRQMASK = 5'h18;

  // First offset past the decoded window; 0x1C..0x1F do not hit.
  localparam logic [4:0] OFF_LIMIT   = 5'h1C;

  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_AUTORELOAD = 1;
  localparam int unsigned CTRL_EXPIRED    = 2;

  localparam int unsigned IRQMASK_EXPIRED = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  function automatic logic window_hit(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:5] == base[31:5]) && (addr[4:0] < OFF_LIMIT);
  endfunction

endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-memory bus seen by the MMIO responder.
//   master : the core (drives Address/WriteData/MemWrite/MemRead)
//   slave  : the responder (drives ReadData/Hit)
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );
endinterface

// File: rtl/mmio_port_responder_timer.sv
// mmio_timer: COUNT / COMPARE / CTRL registers and the IDLE/RUN timer FSM.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   we_count      software write to COUNT this cycle
//   we_compare    software write to COMPARE this cycle
//   we_ctrl       software write to CTRL this cycle (EN/AUTORELOAD load, EXPIRED W1C)
//   wdata         store data
//   count         current COUNT
//   compare       current COMPARE
//   ctrl_rd       CTRL read value {EXPIRED, AUTORELOAD, EN}, upper bits 0
//   expired       EXPIRED flag
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic        we_ctrl,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic [31:0] ctrl_rd,
  output logic        expired
);

  // The FSM state doubles as the EN bit of CTRL.
  timer_state_t state;
  logic         autoreload;
  logic         match;

  assign match   = (state == RUN) && (count == compare);
  assign ctrl_rd = {29'b0, expired, autoreload, (state == RUN)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      autoreload <= 1'b0;
      expired    <= 1'b0;
      count      <= '0;
      compare    <= '0;
    end else begin
      if (we_compare)
        compare <= wdata;

      // Software writes take priority over the hardware count update.
      if (we_count)
        count <= wdata;
      else if (match)
        count <= autoreload ? '0 : count;
      else if (state == RUN)
        count <= count + 32'd1;

      if (we_ctrl) begin
        state      <= timer_state_t'(wdata[CTRL_EN]);
        autoreload <= wdata[CTRL_AUTORELOAD];
      end else if (match && !autoreload) begin
        state <= IDLE;
      end

      // A hardware set in the match cycle beats a concurrent W1C.
      if (match)
        expired <= 1'b1;
      else if (we_ctrl && wdata[CTRL_EXPIRED])
        expired <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: memory-mapped I/O responder on the core data bus.
// Provides a synchronized input port with rising-edge capture, a 32-bit
// output port register and a compare timer (mmio_timer).
// Optional feature macro: MMIO_IRQ_EN (IRQMASK register and registered Irq).
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   bus      data-memory bus (slave side): Address, WriteData, MemWrite,
//            MemRead in; ReadData (0 unless Hit & MemRead), Hit out
//   PortIn   asynchronous external inputs
//   PortOut  output port register
//   Irq      interrupt request (0 when MMIO_IRQ_EN is undefined)
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0040,
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  logic [4:0]          off;
  logic                rd_en;
  logic                wr_en;
  logic [31:0]         rdata;

  logic [IN_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [IN_WIDTH-1:0] sync_val;
  logic [IN_WIDTH-1:0] sync_dly;
  logic [IN_WIDTH-1:0] rise;
  logic [IN_WIDTH-1:0] edge_q;
  logic [IN_WIDTH-1:0] edge_clr;

  logic [31:0]         out_q;
  logic [31:0]         count;
  logic [31:0]         compare;
  logic [31:0]         ctrl_rd;
  logic                expired;

  logic                unused_addr_lsbs;
  assign unused_addr_lsbs = &bus.Address[1:0];

  // Byte lane bits are ignored: decode on the word-aligned offset.
  assign off      = {bus.Address[4:2], 2'b00};
  assign bus.Hit  = window_hit(bus.Address, BASE_ADDR);
  assign rd_en    = bus.Hit & bus.MemRead;
  assign wr_en    = bus.Hit & bus.MemWrite;

  // ---------------- input synchronizer and edge capture ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      sync_dly <= '0;
    end else begin
      sync_q[0] <= PortIn;
      for (int unsigned i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      sync_dly <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign rise     = sync_val & ~sync_dly;

  // Clear-on-read and W1C only ever clear bits that are currently set;
  // a rise in the same cycle re-sets the bit.
  always_comb begin
    edge_clr = '0;
    if (rd_en && off == OFF_EDGE)
      edge_clr = edge_clr | edge_q;
    if (wr_en && off == OFF_EDGE)
      edge_clr = edge_clr | (bus.WriteData[IN_WIDTH-1:0] & edge_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      edge_q <= '0;
    else
      edge_q <= (edge_q & ~edge_clr) | rise;
  end

  // ---------------- output port ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      out_q <= '0;
    else if (wr_en && off == OFF_OUT)
      out_q <= bus.WriteData;
  end

  assign PortOut = out_q;

  // ---------------- timer ----------------
  mmio_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .we_count   (wr_en && off == OFF_COUNT),
    .we_compare (wr_en && off == OFF_COMPARE),
    .we_ctrl    (wr_en && off == OFF_CTRL),
    .wdata      (bus.WriteData),
    .count      (count),
    .compare    (compare),
    .ctrl_rd    (ctrl_rd),
    .expired    (expired)
  );

  // ---------------- interrupt ----------------
`ifdef MMIO_IRQ_EN
  logic [8:0] irq_mask;
  logic       irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && off == OFF_IRQMASK)
        irq_mask <= bus.WriteData[8:0];
      irq_q <= (|(32'(edge_q) & {24'b0, irq_mask[7:0]}))
             | (expired & irq_mask[IRQMASK_EXPIRED]);
    end
  end

  assign Irq = irq_q;
`else
  logic unused_expired;
  assign unused_expired = expired;
  assign Irq = 1'b0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_IN:      rdata = 32'(sync_val);
      OFF_OUT:     rdata = out_q;
      OFF_EDGE:    rdata = 32'(edge_q);
      OFF_COUNT:   rdata = count;
      OFF_COMPARE: rdata = compare;
      OFF_CTRL:    rdata = ctrl_rd;
`ifdef MMIO_IRQ_EN
      OFF_IRQMASK: rdata = 32'(irq_mask);
`endif
      default:     rdata = '0;
    endcase
  end

  assign bus.ReadData = rd_en ? rdata : '0;

endmodule

// File: tb/tb_mmio_port_responder.sv
module tb_mmio_port_responder;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0040;

  logic       clk;
  logic       reset;
  logic [7:0] port_in;
  logic [31:0] port_out;
  logic       irq;

  mmio_port_responder_if bus();

  mmio_port_responder #(
    .BASE_ADDR   (BASE),
    .IN_WIDTH    (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .PortIn  (port_in),
    .PortOut (port_out),
    .Irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_RD, K_HIT, K_PORT, K_IRQ} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: on every falling edge, compare all pending expectations.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        case (e.kind)
          K_RD:    act = bus.ReadData;
          K_HIT:   act = 32'(bus.Hit);
          K_PORT:  act = port_out;
          default: act = 32'(irq);
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic push(input kind_t k, input logic [31:0] v, input string n);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] addr, input logic r, input logic w,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_hit, input string n);
    bus.Address   = addr;
    bus.MemRead   = r;
    bus.MemWrite  = w;
    bus.WriteData = d;
    push(K_RD, exp_rd, n);
    push(K_HIT, 32'(exp_hit), {n, "_hit"});
    step();
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string n);
    access(BASE + 32'(off), 1'b1, 1'b0, 32'h0, exp, 1'b1, n);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d, input string n);
    access(BASE + 32'(off), 1'b0, 1'b1, d, 32'h0, 1'b1, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    port_in       = 8'h00;
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    repeat (3) step();

    // Reset state
    push(K_PORT, 32'h0, "rst_portout");
    push(K_IRQ,  32'h0, "rst_irq");
    push(K_RD,   32'h0, "rst_rdata");
    step();
    reset = 1'b1;
    step();
    rd(OFF_OUT,   32'h0, "rst_out");
    rd(OFF_COUNT, 32'h0, "rst_count");
    rd(OFF_CTRL,  32'h0, "rst_ctrl");
    rd(OFF_EDGE,  32'h0, "rst_edge");

    // Output port write/read, read+write returns pre-write value
    wr(OFF_OUT, 32'hA5A5_0001, "wr_out");
    push(K_PORT, 32'hA5A5_0001, "portout_wr");
    rd(OFF_OUT, 32'hA5A5_0001, "rd_out");
    access(BASE + 32'h04, 1'b1, 1'b1, 32'h1234_5678, 32'hA5A5_0001, 1'b1, "rdwr_pre");
    rd(OFF_OUT, 32'h1234_5678, "rd_out_post");

    // Asynchronous reset mid-test
    reset = 1'b0;
    push(K_PORT, 32'h0, "async_rst_portout");
    step();
    reset = 1'b1;
    step();
    rd(OFF_OUT, 32'h0, "out_after_rst");

    // Input synchronizer and edge capture
    port_in = 8'h81;
    step();
    rd(OFF_IN,   32'h00, "in_1clk");
    rd(OFF_IN,   32'h81, "in_2clk");
    rd(OFF_EDGE, 32'h81, "edge_set");
    rd(OFF_EDGE, 32'h00, "edge_cor");

    // Edge arriving in the clear-on-read cycle
    port_in = 8'h80;
    repeat (4) step();
    port_in = 8'h81;
    repeat (4) step();
    port_in = 8'h83;
    step();
    step();
    rd(OFF_EDGE, 32'h01, "edge_clr_old");
    rd(OFF_EDGE, 32'h02, "edge_set_wins");
    rd(OFF_EDGE, 32'h00, "edge_cleared");

    // W1C on EDGE clears only written bits
    port_in = 8'h00;
    repeat (4) step();
    port_in = 8'h0C;
    repeat (4) step();
    wr(OFF_EDGE, 32'h04, "w1c_edge");
    rd(OFF_EDGE, 32'h08, "edge_w1c_rem");
    rd(OFF_EDGE, 32'h00, "edge_w1c_cor");
    wr(OFF_IN, 32'hFF, "wr_in_ignored");
    rd(OFF_IN, 32'h0C, "in_ro");

    // One-shot timer
    wr(OFF_COMPARE, 32'd5, "wr_cmp5");
    wr(OFF_CTRL, 32'h1, "wr_ctrl_en");
    rd(OFF_COUNT, 32'd0, "os_count0");
    rd(OFF_COUNT, 32'd1, "os_count1");
    repeat (5) step();
    rd(OFF_COUNT, 32'd5, "os_hold");
    rd(OFF_CTRL, 32'h4, "os_expired");
    wr(OFF_CTRL, 32'h4, "os_w1c");
    rd(OFF_CTRL, 32'h0, "os_cleared");
    rd(OFF_COUNT, 32'd5, "os_hold2");

    // Autoreload, then a CTRL write in the match cycle
    wr(OFF_COUNT, 32'd0, "wr_cnt0");
    wr(OFF_COMPARE, 32'd3, "wr_cmp3");
    wr(OFF_CTRL, 32'h3, "wr_ctrl_ar");
    rd(OFF_COUNT, 32'd0, "ar_c0");
    rd(OFF_COUNT, 32'd1, "ar_c1");
    rd(OFF_COUNT, 32'd2, "ar_c2");
    rd(OFF_COUNT, 32'd3, "ar_c3");
    rd(OFF_COUNT, 32'd0, "ar_c0b");
    rd(OFF_COUNT, 32'd1, "ar_c1b");
    rd(OFF_CTRL, 32'h7, "ar_ctrl");
    wr(OFF_CTRL, 32'h4, "match_ctrl_wr");
    rd(OFF_CTRL, 32'h4, "exp_beats_w1c");
    rd(OFF_COUNT, 32'd0, "ar_reload");
    wr(OFF_CTRL, 32'h4, "ar_w1c");
    rd(OFF_CTRL, 32'h0, "ar_cleared");

    // Wrap 0xFFFF_FFFF -> 0 with COMPARE=0
    wr(OFF_COMPARE, 32'd0, "wr_cmp0");
    wr(OFF_COUNT, 32'hFFFF_FFFF, "wr_cnt_max");
    wr(OFF_CTRL, 32'h1, "wrap_en");
    rd(OFF_COUNT, 32'hFFFF_FFFF, "wrap_max");
    rd(OFF_COUNT, 32'd0, "wrap_zero");
    rd(OFF_CTRL, 32'h4, "wrap_expired");
    rd(OFF_COUNT, 32'd0, "wrap_hold");
    wr(OFF_CTRL, 32'h4, "wrap_w1c");
    rd(OFF_CTRL, 32'h0, "wrap_cleared");

    // COMPARE=0, AUTORELOAD, COUNT=0: expires on first RUN cycle
    wr(OFF_CTRL, 32'h3, "z_en");
    rd(OFF_CTRL, 32'h3, "z_first");
    rd(OFF_CTRL, 32'h7, "z_expired");
    wr(OFF_CTRL, 32'h0, "z_stop");
    rd(OFF_CTRL, 32'h4, "z_stopped");
    wr(OFF_CTRL, 32'h4, "z_w1c");
    rd(OFF_CTRL, 32'h0, "z_cleared");

    // Miss / unused / byte-lane addressing
    wr(OFF_OUT, 32'h0000_BEEF, "wr_out_beef");
    access(BASE + 32'h20, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, "miss_20");
    access(BASE + 32'h1C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "miss_1c");
    access(BASE - 32'h20, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "miss_below");
    push(K_PORT, 32'h0000_BEEF, "miss_no_change");
    access(BASE + 32'h06, 1'b1, 1'b0, 32'h0, 32'h0000_BEEF, 1'b1, "byte_lane");

    // IRQ
`ifdef MMIO_IRQ_EN
    wr(OFF_IRQMASK, 32'h100, "wr_mask");
    rd(OFF_IRQMASK, 32'h100, "rd_mask");
`else
    wr(OFF_IRQMASK, 32'h100, "wr_mask");
    rd(OFF_IRQMASK, 32'h0, "rd_mask_off");
`endif
    wr(OFF_COMPARE, 32'd2, "irq_cmp");
    wr(OFF_COUNT, 32'd0, "irq_cnt");
    wr(OFF_CTRL, 32'h1, "irq_en");
    step();
    step();
    step();
    push(K_IRQ, 32'h0, "irq_latency");
    step();
`ifdef MMIO_IRQ_EN
    push(K_IRQ, 32'h1, "irq_set");
`else
    push(K_IRQ, 32'h0, "irq_tied");
`endif
    wr(OFF_CTRL, 32'h4, "irq_w1c");
`ifdef MMIO_IRQ_EN
    push(K_IRQ, 32'h1, "irq_hold");
`else
    push(K_IRQ, 32'h0, "irq_tied2");
`endif
    step();
    push(K_IRQ, 32'h0, "irq_clear");
    step();

    // Drain the scoreboard with a bounded wait
    for (int n = 0; n < 10 && q.size() > 0; n++)
      @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
